// File: rtl/nonce_tx_arbiter_pkg.sv
// Shared definitions for the nonce transmit arbiter.
//   NONCE_W     : width of one golden nonce / transmitted word
//   CNT_W       : width of the words-sent counter
//   arb_state_t : arbiter FSM encoding (IDLE, SEND, WAIT_HI, WAIT_LO)
//   idx_width() : bits needed to index n items (at least 1)
package nonce_tx_arbiter_pkg;

    localparam int NONCE_W = 32;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nonce_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per requester
//   ptr       : index granted last time; search starts at ptr+1
//   grant_idx : first requesting index at or after ptr+1 (mod NUM_REQ)
//   grant_any : at least one request is present
module rr_pick
    import nonce_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int cand;

    // Walk offsets 1..NUM_REQ so the last-granted index is searched last.
    // With NUM_REQ=1 every candidate folds to index 0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/nonce_tx_arbiter.sv
// Shares one serial transmitter among NUM_CORES hashing cores.
// Each core's golden nonce is parked in a holding slot; slots are granted
// round-robin and each grant sends exactly one 32-bit word.
//   clk, rst_n     : clock, asynchronous active-low reset
//   nonce_valid    : per-core one-cycle nonce strobe
//   nonce_flat     : per-core nonce, core i at [32*i +: 32]
//   work_flush     : new work arrived, drop every pending nonce
//   tx_busy        : transmitter busy
//   tx_send        : one-cycle send strobe to the transmitter
//   tx_word        : word presented to the transmitter
//   pending        : slot i holds an unsent nonce
//   overflow       : sticky, core i strobed while its slot was full
//   overflow_clr   : clear all overflow bits (a same-cycle new overflow wins)
//   tx_count       : words handed to the transmitter, wrapping
//
// Handshake: tx_send is high for the single SEND cycle and only ever follows
// an IDLE cycle in which tx_busy was low. The transmitter acknowledges by
// raising tx_busy and finishes by dropping it; if busy never rises within
// BUSY_WAIT_LIMIT cycles the word is written off and arbitration resumes.
module nonce_tx_arbiter
    import nonce_tx_arbiter_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int BUSY_WAIT_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CORES-1:0]         nonce_valid,
    input  logic [NUM_CORES*NONCE_W-1:0] nonce_flat,
    input  logic                         work_flush,
    input  logic                         tx_busy,
    output logic                         tx_send,
    output logic [NONCE_W-1:0]           tx_word,
    output logic [NUM_CORES-1:0]         pending,
    output logic [NUM_CORES-1:0]         overflow,
    input  logic                         overflow_clr,
    output logic [CNT_W-1:0]             tx_count
);

    localparam int IDX_W  = idx_width(NUM_CORES);
    localparam int WCNT_W = idx_width(BUSY_WAIT_LIMIT + 1);

    arb_state_t           state, state_next;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 grant;
    logic [WCNT_W-1:0]    wait_cnt;
    logic [NONCE_W-1:0]   slots [NUM_CORES];
    logic [NUM_CORES-1:0] slot_clear;
    logic [NUM_CORES-1:0] ovf_set;

    rr_pick #(
        .NUM_REQ (NUM_CORES),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_next = state;
        tx_send    = 1'b0;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                // A flush cycle never grants: the slot may hold stale work.
                if (grant_any && !tx_busy && !work_flush) begin
                    grant      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_send    = 1'b1;
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (wait_cnt == WCNT_W'(BUSY_WAIT_LIMIT - 1)) begin
                    state_next = IDLE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slot being emptied by this cycle's grant; it may refill in the same cycle.
    always_comb begin
        slot_clear = '0;
        if (grant) begin
            slot_clear[grant_idx] = 1'b1;
        end
    end

    assign ovf_set = nonce_valid & pending & ~slot_clear & ~{NUM_CORES{work_flush}};

    // Datapath: transmit word, pointer, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_word  <= '0;
            tx_count <= '0;
            rr_ptr   <= IDX_W'(NUM_CORES - 1);
            wait_cnt <= '0;
        end else begin
            if (grant) begin
                tx_word <= slots[grant_idx];
                rr_ptr  <= grant_idx;
            end
            if (state == SEND) begin
                tx_count <= tx_count + 1'b1;
                wait_cnt <= '0;
            end else if (state == WAIT_HI) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Holding slots, pending and sticky overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                slots[i] <= '0;
            end
            pending  <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (work_flush) begin
                    pending[i] <= 1'b0;
                end else if (nonce_valid[i] && (!pending[i] || slot_clear[i])) begin
                    slots[i]   <= nonce_flat[NONCE_W*i +: NONCE_W];
                    pending[i] <= 1'b1;
                end else if (slot_clear[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            overflow <= (overflow & ~{NUM_CORES{overflow_clr}}) | ovf_set;
        end
    end

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Directed bench for nonce_tx_arbiter (NUM_CORES=4, BUSY_WAIT_LIMIT=8).
// A small transmitter model answers tx_send and pops an expected-word queue.
module tb_nonce_tx_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    nonce_valid;
    logic [N*32-1:0] nonce_flat;
    logic            work_flush;
    logic            tx_busy;
    logic            tx_send;
    logic [31:0]     tx_word;
    logic [N-1:0]    pending;
    logic [N-1:0]    overflow;
    logic            overflow_clr;
    logic [15:0]     tx_count;

    int          n_tests;
    int          n_fail;
    int          n_sent;
    int          cyc;
    logic [31:0] exp_q[$];
    int          send_cyc_q[$];

    // transmitter model state
    logic        model_en;
    logic        arm;
    int          hold;
    int          busy_len;
    logic [31:0] exp_word;

    nonce_tx_arbiter #(
        .NUM_CORES       (N),
        .BUSY_WAIT_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nonce_valid  (nonce_valid),
        .nonce_flat   (nonce_flat),
        .work_flush   (work_flush),
        .tx_busy      (tx_busy),
        .tx_send      (tx_send),
        .tx_word      (tx_word),
        .pending      (pending),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .tx_count     (tx_count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transmitter model + scoreboard: busy rises the cycle after send and is
    // held for busy_len cycles; with model_en=0 busy never rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy = 1'b0;
            arm     = 1'b0;
            hold    = 0;
        end else if (tx_send) begin
            check("send_while_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_send", {31'd0, tx_send}, 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                check("tx_word", tx_word, exp_word);
            end
            send_cyc_q.push_back(cyc);
            n_sent++;
            if (model_en) arm = 1'b1;
        end else if (arm) begin
            tx_busy = 1'b1;
            hold    = busy_len - 1;
            arm     = 1'b0;
        end else if (tx_busy) begin
            if (hold == 0) tx_busy = 1'b0;
            else hold--;
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_core(input int i, input logic [31:0] w);
        nonce_valid[i]        = 1'b1;
        nonce_flat[32*i +: 32] = w;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        nonce_valid  = '0;
        work_flush   = 1'b0;
        overflow_clr = 1'b0;
        model_en     = 1'b1;
        exp_q.delete();
        send_cyc_q.delete();
        n_sent = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_sent(input int target, input int budget);
        int b;
        b = budget;
        while (n_sent < target && b > 0) begin
            tick();
            b--;
        end
        check("send_wait_budget", n_sent, target);
    endtask

    task automatic wait_send_strobe(input int budget);
        int b;
        b = budget;
        while (!tx_send && b > 0) begin
            tick();
            b--;
        end
        check("send_strobe_seen", {31'd0, tx_send}, 32'd1);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        busy_len   = 40;
        nonce_flat = '0;
        rst_n      = 1'b0;
        nonce_valid  = '0;
        work_flush   = 1'b0;
        overflow_clr = 1'b0;
        model_en     = 1'b1;
        #1;
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_overflow", {28'd0, overflow}, 32'd0);
        check("rst_tx_count", {16'd0, tx_count}, 32'd0);

        // single nonce, latency
        apply_reset();
        exp_q.push_back(32'hDEADBEEF);
        set_core(2, 32'hDEADBEEF);
        tick();
        nonce_valid = '0;
        check("lat_pending", {28'd0, pending}, 32'h4);
        tick();
        check("lat_send", {31'd0, tx_send}, 32'd1);
        check("lat_pending_clr", {28'd0, pending}, 32'h0);
        wait_sent(1, 100);
        repeat (50) tick();
        check("single_count", {16'd0, tx_count}, 32'd1);
        check("single_pending", {28'd0, pending}, 32'h0);

        // refill of the slot in its own grant cycle: captured, no overflow
        exp_q.push_back(32'h77);
        exp_q.push_back(32'h78);
        set_core(0, 32'h77);
        tick();
        set_core(0, 32'h78);
        tick();
        nonce_valid = '0;
        check("regrant_pending", {28'd0, pending}, 32'h1);
        check("regrant_overflow", {28'd0, overflow}, 32'h0);
        wait_sent(3, 200);
        repeat (50) tick();
        check("regrant_drain", exp_q.size(), 32'd0);
        check("regrant_count", {16'd0, tx_count}, 32'd3);

        // simultaneous nonces from all cores
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h10 + i);
            set_core(i, 32'h10 + i);
        end
        tick();
        nonce_valid = '0;
        check("simul_pending", {28'd0, pending}, 32'hF);
        wait_sent(4, 400);
        repeat (50) tick();
        check("simul_drain", exp_q.size(), 32'd0);
        check("simul_count", {16'd0, tx_count}, 32'd4);

        // fairness: cores 1 and 3 keep re-requesting after each grant
        apply_reset();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h101);
        exp_q.push_back(32'h301);
        exp_q.push_back(32'h102);
        set_core(1, 32'h100);
        set_core(3, 32'h300);
        tick();
        nonce_valid = '0;
        for (int k = 0; k < 4; k++) begin
            wait_send_strobe(200);
            if (k < 3) begin
                if (k % 2 == 0) set_core(1, 32'h101 + k / 2);
                else            set_core(3, 32'h301 + k / 2);
            end
            tick();
            nonce_valid = '0;
        end
        wait_sent(5, 200);
        repeat (50) tick();
        check("rr_drain", exp_q.size(), 32'd0);

        // overflow while a word is on the wire
        apply_reset();
        exp_q.push_back(32'h51);
        exp_q.push_back(32'hA);
        set_core(1, 32'h51);
        tick();
        nonce_valid = '0;
        wait_sent(1, 50);
        repeat (5) tick();
        set_core(0, 32'hA);
        tick();
        nonce_valid = '0;
        set_core(0, 32'hB);
        tick();
        nonce_valid = '0;
        check("ovf_set", {28'd0, overflow}, 32'h1);
        check("ovf_pending", {28'd0, pending}, 32'h1);
        wait_sent(2, 200);
        repeat (50) tick();
        check("ovf_drain", exp_q.size(), 32'd0);
        check("ovf_sticky", {28'd0, overflow}, 32'h1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_clr", {28'd0, overflow}, 32'h0);

        // flush while a word is in WAIT_LO
        apply_reset();
        exp_q.push_back(32'hF0);
        set_core(0, 32'hF0);
        tick();
        nonce_valid = '0;
        wait_sent(1, 50);
        repeat (5) tick();
        set_core(1, 32'hF1);
        set_core(2, 32'hF2);
        tick();
        nonce_valid = '0;
        check("flush_pre_pending", {28'd0, pending}, 32'h6);
        set_core(3, 32'hF3);
        work_flush = 1'b1;
        tick();
        nonce_valid = '0;
        work_flush  = 1'b0;
        check("flush_pending", {28'd0, pending}, 32'h0);
        check("flush_overflow", {28'd0, overflow}, 32'h0);
        repeat (80) tick();
        check("flush_drain", exp_q.size(), 32'd0);
        check("flush_count", {16'd0, tx_count}, 32'd1);

        // busy never rises: abandon after 8 WAIT_HI cycles
        apply_reset();
        model_en = 1'b0;
        exp_q.push_back(32'hC0);
        exp_q.push_back(32'hC1);
        set_core(0, 32'hC0);
        set_core(1, 32'hC1);
        tick();
        nonce_valid = '0;
        wait_sent(2, 100);
        if (send_cyc_q.size() == 2) begin
            check("timeout_gap", send_cyc_q[1] - send_cyc_q[0], 32'd10);
        end
        repeat (2) tick();
        check("timeout_count", {16'd0, tx_count}, 32'd2);

        // asynchronous reset in WAIT_LO
        model_en = 1'b1;
        exp_q.push_back(32'hE2);
        set_core(2, 32'hE2);
        tick();
        nonce_valid = '0;
        wait_sent(3, 50);
        repeat (6) tick();
        set_core(3, 32'h31);
        tick();
        nonce_valid = '0;
        set_core(3, 32'h32);
        tick();
        nonce_valid = '0;
        check("arst_pre_ovf", {28'd0, overflow}, 32'h8);
        #1 rst_n = 1'b0;
        #1;
        check("arst_tx_send", {31'd0, tx_send}, 32'd0);
        check("arst_tx_word", tx_word, 32'd0);
        check("arst_pending", {28'd0, pending}, 32'h0);
        check("arst_overflow", {28'd0, overflow}, 32'h0);
        check("arst_tx_count", {16'd0, tx_count}, 32'd0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nonce_tx_arbiter.md
Name: nonce_tx_arbiter

Overview:
- Shares one `serial_transmit` instance among `NUM_CORES` hashing cores that each report golden nonces.
- Captures each core's 32-bit nonce in a per-core holding register and grants the transmitter round-robin.
- Sequences the `send`/`busy` handshake so exactly one 4-byte word goes out per grant.
- On new work (`rx_done` from `serial_receive`), flushes stale pending nonces.

Parameters:
- NUM_CORES, 4, number of requesting cores; legal range 1..16.
- BUSY_WAIT_LIMIT, 8, cycles to wait for `tx_busy` to rise after `tx_send` before abandoning the grant.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- nonce_valid  in  NUM_CORES  one-cycle pulse per core: a golden nonce is present.
- nonce_flat  in  NUM_CORES*32  nonces; core i occupies bits [32*i+31:32*i].
- work_flush  in  1  pulse on new work (tie to `rx_done`); discards all pending nonces.
- tx_busy  in  1  `busy` from `serial_transmit`.
- tx_send  out  1  `send` to `serial_transmit`.
- tx_word  out  32  `word` to `serial_transmit`.
- pending  out  NUM_CORES  holding register i is occupied.
- overflow  out  NUM_CORES  sticky: core i produced a nonce while its slot was full.
- overflow_clr  in  1  clears all `overflow` bits.
- tx_count  out  16  words handed to the transmitter; wraps at 65535 to 0.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE; `pending`=0, `overflow`=0, `tx_send`=0, `tx_word`=0, `tx_count`=0, RR pointer=NUM_CORES-1, holding regs=0.
- Capture: `nonce_valid[i]` with `pending[i]`=0 loads slot i and sets `pending[i]` next cycle.
- Full slot: `nonce_valid[i]` with `pending[i]`=1 keeps the old nonce and sets `overflow[i]`.
- Exception: if slot i is being granted (cleared) this same cycle, the new nonce is captured and there is no overflow.
- `overflow_clr` clears all bits. If it coincides with a new overflow event, set wins.
- Flush: `work_flush`=1 clears every `pending` bit. A `nonce_valid` in the same cycle is dropped (stale work) and does not set `overflow`.
- Flush in SEND/WAIT states does not abort the word already handed to the transmitter.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE: if any `pending` and `tx_busy`=0 and no `work_flush` this cycle, grant the first pending index searching upward from RR pointer+1 modulo NUM_CORES. On grant:
  - latch the slot into `tx_word` and clear `pending[g]`;
  - set RR pointer=g;
  - go to SEND.
- SEND: `tx_send`=1 for exactly this one cycle; increment `tx_count`; go to WAIT_HI.
- WAIT_HI: `tx_send`=0. `tx_busy`=1 -> WAIT_LO. If BUSY_WAIT_LIMIT cycles pass without busy -> IDLE (word considered lost; counter not decremented).
- WAIT_LO: `tx_busy`=0 -> IDLE.
- Latency: nonce pulse at cycle t, idle arbiter and idle transmitter -> `pending` at t+1, grant at t+1, `tx_send` at t+2.
- `tx_word` is stable from SEND until the next grant.
- Back-to-back: minimum one IDLE cycle between WAIT_LO exit and the next SEND. This guarantees `send` is never asserted while the transmitter is busy.
- Fairness: a core that is continuously pending is granted within NUM_CORES grants.
- NUM_CORES=1: the RR logic degenerates to always granting index 0.

Decomposition:
- Shared package: the state encoding constants IDLE/SEND/WAIT_HI/WAIT_LO, and the nonce width constant 32.
- One sub-module, `rr_pick`: combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: grant index and any-grant flag.

Test Plan:
- Single nonce: core 2 pulses 0xDEADBEEF; transmitter model raises busy 1 cycle after send and holds it 40 cycles -> one `tx_send` pulse with `tx_word`=0xDEADBEEF, `tx_count`=1, `pending`=0 afterwards.
- Simultaneous nonces: cores 0..3 pulse 0x10,0x11,0x12,0x13 in the same cycle -> four sends in order 0x10,0x11,0x12,0x13. Each send is issued only after busy falls, and `send` is never high while busy is high.
- Round-robin fairness: core 1 pulses again right after each of its grants while core 3 stays pending -> grant order alternates 1,3,1,3.
- Overflow: core 0 pulses 0xA then 0xB while 0xA is still pending and a core 1 word is on the wire -> 0xA is sent, 0xB is never sent, `overflow[0]`=1. `overflow_clr` returns it to 0.
- Flush: cores 1 and 2 pending, core 3 pulses in the same cycle as `work_flush` -> `pending`=0, no sends follow, `overflow`=0. A word already in WAIT_LO completes normally.
- Timeout and reset: busy held low after send -> IDLE after 8 cycles. Asserting `rst_n`=0 mid WAIT_LO -> all outputs return to their reset values immediately (asynchronously).
